mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between the openmips instruction-fetch

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_DM   = 2'b10
  } owner_e;

  localparam logic [3:0]  MEM_SEL_ALL = 4'b1111;
  localparam int unsigned DWIN_W      = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and data
// ports, with bounded data priority and 1-cycle routed read responses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_DWIN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [3:0]    dm_sel_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic          dm_gnt_o,
  output logic          dm_rvalid_o,
  output logic [DW-1:0] dm_rdata_o,
  output logic          mem_ce_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_sel_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  input  logic [DW-1:0] mem_data_i,
  output logic          stallreq_o
);

  localparam logic [DWIN_W-1:0] DWIN_MAX = DWIN_W'(MAX_DWIN);

  owner_e            r_owner;
  owner_e            w_owner_nxt;
  logic              r_dm_we;
  logic [DWIN_W-1:0] r_dwin_cnt;
  logic              w_dwin_full;
  logic              w_if_gnt;
  logic              w_dm_gnt;

  // Data wins ties until fetch has lost MAX_DWIN times in a row; grants are held
  // low during reset so every output reads zero while rst is asserted.
  always_comb begin
    w_dwin_full = (r_dwin_cnt == DWIN_MAX);
    w_if_gnt    = 1'b0;
    w_dm_gnt    = 1'b0;
    if (!rst) begin
      if (dm_req_i && !(if_req_i && w_dwin_full)) begin
        w_dm_gnt = 1'b1;
      end else if (if_req_i) begin
        w_if_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwin_cnt <= '0;
    end else if (!if_req_i || w_if_gnt) begin
      r_dwin_cnt <= '0;
    end else if (w_dm_gnt && !w_dwin_full) begin
      r_dwin_cnt <= r_dwin_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_NONE;
      r_dm_we <= 1'b0;
    end else begin
      r_owner <= w_owner_nxt;
      r_dm_we <= w_dm_gnt & dm_we_i;
    end
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_dm_gnt) begin
      w_owner_nxt = OWN_DM;
    end else if (w_if_gnt) begin
      w_owner_nxt = OWN_IF;
    end
  end

  always_comb begin
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    dm_rvalid_o = 1'b0;
    dm_rdata_o  = '0;
    case (r_owner)
      OWN_IF: begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = mem_data_i;
      end
      OWN_DM: begin
        dm_rvalid_o = 1'b1;
        dm_rdata_o  = r_dm_we ? '0 : mem_data_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_ce_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_sel_o  = '0;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (w_dm_gnt) begin
      mem_ce_o   = 1'b1;
      mem_we_o   = dm_we_i;
      mem_sel_o  = dm_sel_i;
      mem_addr_o = dm_addr_i;
      mem_data_o = dm_wdata_i;
    end else if (w_if_gnt) begin
      mem_ce_o   = 1'b1;
      mem_sel_o  = MEM_SEL_ALL;
      mem_addr_o = if_addr_i;
    end
  end

  assign if_gnt_o   = w_if_gnt;
  assign dm_gnt_o   = w_dm_gnt;
  assign stallreq_o = !rst && ((if_req_i && !w_if_gnt) || (dm_req_i && !w_dm_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: memory environment, rule-level reference model, directed tests.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [3:0]    dm_sel;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_ce, mem_we;
  logic [3:0]    mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdat, mem_rdat;
  logic          stallreq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DWIN(MAXD)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_sel_i(dm_sel), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid),
    .dm_rdata_o(dm_rdata),
    .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_sel_o(mem_sel),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdat), .mem_data_i(mem_rdat),
    .stallreq_o(stallreq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h3401_1100 : (32'hA500_0000 | 32'(i));
  endfunction

  // Memory seen by the DUT, and the model's own shadow copy.
  logic [31:0] ram    [0:255];
  logic [31:0] shadow [0:255];

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    mem_rdat = '0;
  end

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_sel[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdat[8*b +: 8];
      mem_rdat <= ram[mem_addr[9:2]];
    end
  end

  // Reference model: grant rules, starvation count and one pending response.
  int          m_dwins = 0;
  int          m_pend  = 0;     // 0 none, 1 fetch, 2 data
  logic [31:0] m_pdata = '0;

  always @(negedge clk) begin
    bit eg_dm, eg_if;
    int idx;
    if (rst) begin
      chk("rst_if_gnt", 32'(if_gnt), 32'(0));
      chk("rst_dm_gnt", 32'(dm_gnt), 32'(0));
      chk("rst_if_rvalid", 32'(if_rvalid), 32'(0));
      chk("rst_dm_rvalid", 32'(dm_rvalid), 32'(0));
      chk("rst_mem_ce", 32'(mem_ce), 32'(0));
      chk("rst_stall", 32'(stallreq), 32'(0));
      m_pend  = 0;
      m_dwins = 0;
    end else begin
      eg_dm = dm_req && (!if_req || m_dwins < MAXD);
      eg_if = if_req && !eg_dm;
      chk("m_if_gnt", 32'(if_gnt), 32'(eg_if));
      chk("m_dm_gnt", 32'(dm_gnt), 32'(eg_dm));
      chk("m_stall", 32'(stallreq), 32'((if_req && !eg_if) || (dm_req && !eg_dm)));
      chk("m_mem_ce", 32'(mem_ce), 32'(eg_if || eg_dm));
      chk("m_mem_we", 32'(mem_we), 32'(eg_dm && dm_we));
      chk("m_mem_sel", 32'(mem_sel), eg_dm ? 32'(dm_sel) : (eg_if ? 32'hF : 32'h0));
      chk("m_mem_addr", mem_addr, eg_dm ? dm_addr : (eg_if ? if_addr : 32'h0));
      chk("m_mem_data", mem_wdat, eg_dm ? dm_wdata : 32'h0);
      chk("m_if_rvalid", 32'(if_rvalid), 32'(m_pend == 1));
      chk("m_if_rdata", if_rdata, (m_pend == 1) ? m_pdata : 32'h0);
      chk("m_dm_rvalid", 32'(dm_rvalid), 32'(m_pend == 2));
      chk("m_dm_rdata", dm_rdata, (m_pend == 2) ? m_pdata : 32'h0);
      m_pend = 0;
      if (eg_dm) begin
        idx     = int'(dm_addr[9:2]);
        m_pend  = 2;
        m_pdata = dm_we ? 32'h0 : shadow[idx];
        if (dm_we)
          for (int b = 0; b < 4; b++)
            if (dm_sel[b]) shadow[idx][8*b +: 8] = dm_wdata[8*b +: 8];
      end else if (eg_if) begin
        m_pend  = 1;
        m_pdata = shadow[int'(if_addr[9:2])];
      end
      if (!if_req || eg_if) m_dwins = 0;
      else if (eg_dm && m_dwins < MAXD) m_dwins = m_dwins + 1;
    end
  end

  task automatic drive_idle();
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_sel = 4'h0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] dm_seq, if_seq;
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Fetch only
    if_req = 1'b1; if_addr = 32'h0000_0010;
    @(negedge clk);
    chk("fetch_gnt", 32'(if_gnt), 32'(1));
    chk("fetch_sel", 32'(mem_sel), 32'hF);
    chk("fetch_stall", 32'(stallreq), 32'(0));
    step(); drive_idle();
    @(negedge clk);
    chk("fetch_rvalid", 32'(if_rvalid), 32'(1));
    chk("fetch_rdata", if_rdata, 32'h3401_1100);

    // Collision
    step();
    if_req = 1'b1; if_addr = 32'h0000_0014;
    dm_req = 1'b1; dm_sel = 4'hF; dm_addr = 32'h0000_0100;
    @(negedge clk);
    chk("coll_dm_gnt", 32'(dm_gnt), 32'(1));
    chk("coll_if_gnt", 32'(if_gnt), 32'(0));
    chk("coll_stall", 32'(stallreq), 32'(1));
    step(); dm_req = 1'b0;
    @(negedge clk);
    chk("coll_if_gnt2", 32'(if_gnt), 32'(1));
    chk("coll_dm_rvalid", 32'(dm_rvalid), 32'(1));
    chk("coll_dm_rdata", dm_rdata, 32'hA500_0040);
    step(); drive_idle();
    @(negedge clk);
    chk("coll_if_rdata", if_rdata, 32'hA500_0005);

    // Starvation bound
    for (int i = 0; i < 6; i++) begin
      step();
      if_req = 1'b1; if_addr = 32'h0000_0080;
      dm_req = 1'b1; dm_sel = 4'hF; dm_addr = 32'h0000_0040 + 32'(4 * i);
      @(negedge clk);
      dm_seq[i] = dm_gnt;
      if_seq[i] = if_gnt;
    end
    chk("starve_dm_seq", 32'(dm_seq), 32'(6'b101111));
    chk("starve_if_seq", 32'(if_seq), 32'(6'b010000));
    step(); drive_idle();

    // Partial write then read back
    step();
    dm_req = 1'b1; dm_we = 1'b1; dm_sel = 4'b0011;
    dm_addr = 32'h0000_0200; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_mem_we", 32'(mem_we), 32'(1));
    chk("wr_mem_sel", 32'(mem_sel), 32'h3);
    step(); drive_idle();
    @(negedge clk);
    chk("wr_ack", 32'(dm_rvalid), 32'(1));
    chk("wr_rdata", dm_rdata, 32'h0);
    step();
    dm_req = 1'b1; dm_sel = 4'hF; dm_addr = 32'h0000_0200;
    step(); drive_idle();
    @(negedge clk);
    chk("rd_after_wr", dm_rdata, 32'hA500_BEEF);

    // Back-to-back fetch
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 4) begin
        if_req = 1'b1; if_addr = 32'h0000_0020 + 32'(4 * i);
      end else begin
        drive_idle();
      end
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_rvalid", 32'(if_rvalid), 32'(1));
        chk("b2b_rdata", if_rdata, 32'hA500_0008 + 32'(i - 1));
      end
    end

    // Reset while a data read is in flight
    step();
    dm_req = 1'b1; dm_addr = 32'h0000_0030; dm_sel = 4'hF; if_req = 1'b1;
    @(negedge clk);
    chk("rstmid_dm_gnt", 32'(dm_gnt), 32'(1));
    step(); rst = 1'b1;
    @(negedge clk);
    chk("rstmid_dm_rvalid", 32'(dm_rvalid), 32'(0));
    chk("rstmid_stall", 32'(stallreq), 32'(0));
    step(); rst = 1'b0; drive_idle();
    @(negedge clk);
    chk("rstrel_dm_rvalid", 32'(dm_rvalid), 32'(0));
    chk("rstrel_if_rvalid", 32'(if_rvalid), 32'(0));

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
